// File: rtl/cpu6502_ldst_core.sv
// cpu6502_ldst_core
//   Cycle-accurate NMOS-6502 load/store core: LDA/LDX/LDY/STA/STX/STY in
//   immediate, zp, zp indexed, abs, abs indexed and (zp),Y modes. Every other
//   opcode runs as a 2-cycle, 1-byte NOP; all of them except $EA also pulse
//   `illegal`.
// Parameters
//   USE_VECTOR : 1 = start PC comes from RESET_VEC/RESET_VEC+1, 0 = START_PC
//   RESET_VEC  : address of the low byte of the reset vector
//   START_PC   : start address when USE_VECTOR = 0
// Ports
//   clk, reset              : clock; synchronous active-high reset
//   rdy                     : 0 stalls read cycles (the cycle repeats)
//   di                      : read data for the current ab
//   dout                    : write data, valid while we = 1 (the 6502 "do" pin)
//   ab, we, sync            : registered address bus, write strobe, opcode fetch
//   reg_a, reg_x, reg_y     : architectural registers
//   flag_n, flag_z          : status flags
//   illegal                 : one-cycle pulse after an unsupported opcode fetch
module cpu6502_ldst_core #(
  parameter bit          USE_VECTOR = 1'b1,
  parameter logic [15:0] RESET_VEC  = 16'hFFFC,
  parameter logic [15:0] START_PC   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic [7:0]  di,
  output logic [7:0]  dout,
  output logic [15:0] ab,
  output logic        we,
  output logic        sync,
  output logic [7:0]  reg_a,
  output logic [7:0]  reg_x,
  output logic [7:0]  reg_y,
  output logic        flag_n,
  output logic        flag_z,
  output logic        illegal
);
  typedef enum logic [3:0] {S_RESET, S_VEC_LO, S_VEC_HI, S_FETCH, S_OPER1, S_OPER2,
                            S_INDEX, S_PTR_LO, S_PTR_HI, S_EXEC} state_t;
  typedef enum logic [2:0] {M_NONE, M_IMM, M_ZP, M_ZPI, M_ABS, M_ABSI, M_INDY} mode_t;
  typedef enum logic [1:0] {R_A, R_X, R_Y} reg_t;

  state_t      state_q, state_d;
  logic [15:0] ab_q, ab_d, pc_q, pc_d, ea_q, ea_d, pc_inc;
  logic        we_q, we_d, sync_q, sync_d, ill_q, ill_d, n_q, n_d, z_q, z_d;
  logic [7:0]  do_q, do_d, a_q, a_d, x_q, x_d, y_q, y_d, lo_q, lo_d;
  mode_t       mode_q, mode_d, dec_mode;
  reg_t        reg_q, reg_d, dec_reg;
  logic        store_q, store_d, idxy_q, idxy_d, dec_store, dec_idx_y, dec_ill;
  logic [7:0]  idx, src;
  logic [8:0]  sum;
  logic        load_en;

  // Opcode decode on the aaa/bbb/cc fields: aaa=100 stores, aaa=101 loads.
  always_comb begin
    dec_mode  = M_NONE;
    dec_reg   = R_A;
    dec_store = ~di[5];
    dec_idx_y = 1'b0;
    if (di[7:6] == 2'b10) begin
      unique case (di[1:0])
        2'b01: begin
          dec_reg = R_A;
          case (di[4:2])
            3'b001: dec_mode = M_ZP;
            3'b010: dec_mode = dec_store ? M_NONE : M_IMM;
            3'b011: dec_mode = M_ABS;
            3'b100: begin dec_mode = M_INDY; dec_idx_y = 1'b1; end
            3'b101: dec_mode = M_ZPI;
            3'b110: begin dec_mode = M_ABSI; dec_idx_y = 1'b1; end
            3'b111: dec_mode = M_ABSI;
            default: dec_mode = M_NONE;
          endcase
        end
        2'b10, 2'b00: begin
          // LDX/STX index with Y, LDY/STY index with X
          dec_reg   = di[1] ? R_X : R_Y;
          dec_idx_y = di[1];
          case (di[4:2])
            3'b000: dec_mode = dec_store ? M_NONE : M_IMM;
            3'b001: dec_mode = M_ZP;
            3'b011: dec_mode = M_ABS;
            3'b101: dec_mode = M_ZPI;
            3'b111: dec_mode = dec_store ? M_NONE : M_ABSI;
            default: dec_mode = M_NONE;
          endcase
        end
        default: dec_mode = M_NONE;
      endcase
    end
    dec_ill = (dec_mode == M_NONE) && (di != 8'hEA);
  end

  always_comb begin
    state_d = state_q; ab_d = ab_q; we_d = we_q; do_d = do_q; sync_d = sync_q;
    ill_d = ill_q; pc_d = pc_q; ea_d = ea_q; lo_d = lo_q;
    a_d = a_q; x_d = x_q; y_d = y_q; n_d = n_q; z_d = z_q;
    mode_d = mode_q; reg_d = reg_q; store_d = store_q; idxy_d = idxy_q;
    load_en = 1'b0;
    pc_inc  = pc_q + 16'd1;
    idx     = idxy_q ? y_q : x_q;
    sum     = {1'b0, lo_q} + {1'b0, idx};
    case (reg_q)
      R_X:     src = x_q;
      R_Y:     src = y_q;
      default: src = a_q;
    endcase
    // A low rdy freezes read cycles only; a write cycle always completes.
    if (rdy || we_q) begin
      we_d = 1'b0; sync_d = 1'b0; ill_d = 1'b0;
      unique case (state_q)
        S_RESET, S_VEC_LO: begin
          lo_d = di; ab_d = RESET_VEC + 16'd1; state_d = S_VEC_HI;
        end
        S_VEC_HI: begin
          pc_d = {di, lo_q}; ab_d = {di, lo_q}; sync_d = 1'b1; state_d = S_FETCH;
        end
        S_FETCH: begin
          pc_d = pc_inc; ab_d = pc_inc;
          mode_d = dec_mode; reg_d = dec_reg; store_d = dec_store; idxy_d = dec_idx_y;
          ill_d = dec_ill;
          state_d = (dec_mode == M_NONE) ? S_EXEC : S_OPER1;
        end
        S_OPER1: begin
          pc_d = pc_inc; lo_d = di;
          case (mode_q)
            M_IMM: begin load_en = 1'b1; ab_d = pc_inc; sync_d = 1'b1; state_d = S_FETCH; end
            M_ZP:  begin ab_d = {8'h00, di}; we_d = store_q; state_d = S_EXEC; end
            // zp indexed wraps inside page zero
            M_ZPI: begin ab_d = {8'h00, di}; ea_d = {8'h00, di + idx}; state_d = S_INDEX; end
            M_INDY: begin ab_d = {8'h00, di}; state_d = S_PTR_LO; end
            default: begin ab_d = pc_inc; state_d = S_OPER2; end
          endcase
        end
        S_PTR_LO: begin
          lo_d = di; ab_d = {8'h00, ab_q[7:0] + 8'd1}; state_d = S_PTR_HI;
        end
        S_OPER2, S_PTR_HI: begin
          if (state_q == S_OPER2) pc_d = pc_inc;
          if (mode_q == M_ABS) begin
            ab_d = {di, lo_q}; we_d = store_q; state_d = S_EXEC;
          end else begin
            // First try {base_hi, sum_lo}; a carry or a store needs the fixup cycle.
            ab_d = {di, sum[7:0]};
            ea_d = {di + {7'd0, sum[8]}, sum[7:0]};
            state_d = (sum[8] || store_q) ? S_INDEX : S_EXEC;
          end
        end
        S_INDEX: begin
          ab_d = ea_q; we_d = store_q; state_d = S_EXEC;
        end
        S_EXEC: begin
          load_en = (mode_q != M_NONE) && !store_q;
          ab_d = pc_q; sync_d = 1'b1; state_d = S_FETCH;
        end
        default: begin
          ab_d = pc_q; sync_d = 1'b1; state_d = S_FETCH;
        end
      endcase
      if (we_d) do_d = src;
      if (load_en) begin
        case (reg_q)
          R_X:     x_d = di;
          R_Y:     y_d = di;
          default: a_d = di;
        endcase
        n_d = di[7];
        z_d = (di == 8'h00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= USE_VECTOR ? S_VEC_LO : S_FETCH;
      ab_q    <= USE_VECTOR ? RESET_VEC : START_PC;
      pc_q    <= START_PC;
      sync_q  <= !USE_VECTOR;
      we_q <= 1'b0; do_q <= 8'h00; ill_q <= 1'b0;
      a_q <= 8'h00; x_q <= 8'h00; y_q <= 8'h00; n_q <= 1'b0; z_q <= 1'b0;
    end else begin
      state_q <= state_d; ab_q <= ab_d; pc_q <= pc_d; sync_q <= sync_d;
      we_q <= we_d; do_q <= do_d; ill_q <= ill_d;
      a_q <= a_d; x_q <= x_d; y_q <= y_d; n_q <= n_d; z_q <= z_d;
    end
  end

  // Per-instruction scratch state; always written before it is used.
  always_ff @(posedge clk) begin
    mode_q <= mode_d; reg_q <= reg_d; store_q <= store_d; idxy_q <= idxy_d;
    lo_q <= lo_d; ea_q <= ea_d;
  end

  assign ab = ab_q;       assign we = we_q;       assign dout = do_q;
  assign sync = sync_q;   assign illegal = ill_q;
  assign reg_a = a_q;     assign reg_x = x_q;     assign reg_y = y_q;
  assign flag_n = n_q;    assign flag_z = z_q;
endmodule

// File: tb/tb_cpu6502_ldst_core.sv
module tb_cpu6502_ldst_core;
  logic clk = 1'b0, reset = 1'b1, rdy = 1'b1;
  logic [7:0] di, dout, reg_a, reg_x, reg_y;
  logic [15:0] ab;
  logic we, sync, flag_n, flag_z, illegal;

  cpu6502_ldst_core dut (.clk(clk), .reset(reset), .rdy(rdy), .di(di), .dout(dout),
    .ab(ab), .we(we), .sync(sync), .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y),
    .flag_n(flag_n), .flag_z(flag_z), .illegal(illegal));

  always #5 clk = ~clk;

  logic [7:0] bus_mem [0:65535];
  logic [7:0] mmem    [0:65535];
  assign di = bus_mem[ab];
  always @(posedge clk) if (we && !reset) bus_mem[ab] <= dout;

  int checks = 0, errors = 0;

  typedef struct packed {
    logic [15:0] ab; logic we; logic [7:0] d; logic sync; logic ill;
    logic [7:0] a, x, y; logic n, z;
  } exp_t;
  exp_t expq[$];
  logic [7:0] m_a, m_x, m_y; logic m_n, m_z;

  localparam logic [1:0] K_NOP = 0, K_ILL = 1, K_LD = 2, K_ST = 3;
  localparam logic [1:0] RA = 0, RX = 1, RY = 2;
  localparam logic [2:0] MI = 0, MZ = 1, MZI = 2, MA = 3, MAI = 4, MIY = 5;

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    bus_mem[a] = v; mmem[a] = v;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic w, input logic [7:0] d,
                      input logic s, input logic il);
    exp_t e;
    e.ab = a; e.we = w; e.d = d; e.sync = s; e.ill = il;
    e.a = m_a; e.x = m_x; e.y = m_y; e.n = m_n; e.z = m_z;
    expq.push_back(e);
  endtask

  task automatic ld(input logic [1:0] r, input logic [7:0] v);
    if (r == RX) m_x = v; else if (r == RY) m_y = v; else m_a = v;
    m_n = v[7]; m_z = (v == 8'h00);
  endtask

  // Instruction-level model: expands one instruction into its bus cycles.
  task automatic model_instr(inout logic [15:0] pc);
    logic [7:0] op, b, idx, v, dec;
    logic [1:0] kind, r; logic [2:0] md; logic iy;
    logic [15:0] p1, p2, base, ea;
    op = mmem[pc]; p1 = pc + 16'd1; p2 = p1 + 16'd1;
    case (op)
      8'hA9: dec = {K_LD, RA, MI, 1'b0};  8'hA5: dec = {K_LD, RA, MZ, 1'b0};
      8'hB5: dec = {K_LD, RA, MZI, 1'b0}; 8'hAD: dec = {K_LD, RA, MA, 1'b0};
      8'hBD: dec = {K_LD, RA, MAI, 1'b0}; 8'hB9: dec = {K_LD, RA, MAI, 1'b1};
      8'hB1: dec = {K_LD, RA, MIY, 1'b1};
      8'h85: dec = {K_ST, RA, MZ, 1'b0};  8'h95: dec = {K_ST, RA, MZI, 1'b0};
      8'h8D: dec = {K_ST, RA, MA, 1'b0};  8'h9D: dec = {K_ST, RA, MAI, 1'b0};
      8'h99: dec = {K_ST, RA, MAI, 1'b1}; 8'h91: dec = {K_ST, RA, MIY, 1'b1};
      8'hA2: dec = {K_LD, RX, MI, 1'b0};  8'hA6: dec = {K_LD, RX, MZ, 1'b0};
      8'hB6: dec = {K_LD, RX, MZI, 1'b1}; 8'hAE: dec = {K_LD, RX, MA, 1'b0};
      8'hBE: dec = {K_LD, RX, MAI, 1'b1};
      8'h86: dec = {K_ST, RX, MZ, 1'b0};  8'h96: dec = {K_ST, RX, MZI, 1'b1};
      8'h8E: dec = {K_ST, RX, MA, 1'b0};
      8'hA0: dec = {K_LD, RY, MI, 1'b0};  8'hA4: dec = {K_LD, RY, MZ, 1'b0};
      8'hB4: dec = {K_LD, RY, MZI, 1'b0}; 8'hAC: dec = {K_LD, RY, MA, 1'b0};
      8'hBC: dec = {K_LD, RY, MAI, 1'b0};
      8'h84: dec = {K_ST, RY, MZ, 1'b0};  8'h94: dec = {K_ST, RY, MZI, 1'b0};
      8'h8C: dec = {K_ST, RY, MA, 1'b0};
      8'hEA: dec = {K_NOP, 6'd0};
      default: dec = {K_ILL, 6'd0};
    endcase
    {kind, r, md, iy} = dec;
    push(pc, 1'b0, 8'h00, 1'b1, 1'b0);
    push(p1, 1'b0, 8'h00, 1'b0, kind == K_ILL);
    if (kind == K_NOP || kind == K_ILL) begin pc = p1; return; end
    idx = iy ? m_y : m_x;
    b = mmem[p1];
    pc = p2;
    ea = {8'h00, b};
    base = 16'h0000;
    case (md)
      MI: begin ld(r, b); return; end
      MZI: begin push({8'h00, b}, 1'b0, 8'h00, 1'b0, 1'b0); ea = {8'h00, b + idx}; end
      MA: begin push(p2, 1'b0, 8'h00, 1'b0, 1'b0); ea = {mmem[p2], b}; pc = p2 + 16'd1; end
      MAI: begin
        push(p2, 1'b0, 8'h00, 1'b0, 1'b0); base = {mmem[p2], b}; pc = p2 + 16'd1;
      end
      MIY: begin
        push({8'h00, b}, 1'b0, 8'h00, 1'b0, 1'b0);
        push({8'h00, b + 8'd1}, 1'b0, 8'h00, 1'b0, 1'b0);
        base = {mmem[{8'h00, b + 8'd1}], mmem[{8'h00, b}]};
      end
      default: ;
    endcase
    if (md == MAI || md == MIY) begin
      ea = base + {8'h00, idx};
      if (ea[15:8] != base[15:8] || kind == K_ST)
        push({base[15:8], ea[7:0]}, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    if (kind == K_ST) begin
      v = (r == RX) ? m_x : (r == RY) ? m_y : m_a;
      push(ea, 1'b1, v, 1'b0, 1'b0);
      mmem[ea] = v;
    end else begin
      push(ea, 1'b0, 8'h00, 1'b0, 1'b0);
      ld(r, mmem[ea]);
    end
  endtask

  task automatic model_reset_and_build(input int n_instr);
    logic [15:0] pc;
    m_a = 0; m_x = 0; m_y = 0; m_n = 0; m_z = 0;
    expq.delete();
    push(16'hFFFC, 1'b0, 8'h00, 1'b0, 1'b0);
    push(16'hFFFD, 1'b0, 8'h00, 1'b0, 1'b0);
    pc = {mmem[16'hFFFD], mmem[16'hFFFC]};
    for (int i = 0; i < n_instr; i++) model_instr(pc);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ab"}, ab, 16'hFFFC);
    chk({tag, "_ctl"}, {we, sync, illegal}, 0);
    chk({tag, "_do"}, dout, 0);
    chk({tag, "_regs"}, {reg_a, reg_x, reg_y, flag_n, flag_z}, 0);
  endtask

  int cyc = 0, last_sync = -1, stall_cnt = 0;
  bit wstall_done = 0, hit = 0;
  int gaps[$];

  // Called at a falling edge; compares every cycle until the queue drains.
  task automatic run_phase(input bit stop_at_store);
    int budget = 0;
    exp_t e;
    while (expq.size() > 0) begin
      e = expq[0];
      checks++;
      if (ab !== e.ab || we !== e.we || (we ? dout : 8'h00) !== e.d || sync !== e.sync ||
          illegal !== e.ill || reg_a !== e.a || reg_x !== e.x || reg_y !== e.y ||
          flag_n !== e.n || flag_z !== e.z) begin
        errors++;
        $display("FAIL cycle %0d: got ab=%h we=%b do=%h sync=%b ill=%b a=%h x=%h y=%h n=%b z=%b; required ab=%h we=%b do=%h sync=%b ill=%b a=%h x=%h y=%h n=%b z=%b",
          cyc, ab, we, dout, sync, illegal, reg_a, reg_x, reg_y, flag_n, flag_z,
          e.ab, e.we, e.d, e.sync, e.ill, e.a, e.x, e.y, e.n, e.z);
      end
      if (sync) begin
        if (last_sync >= 0) gaps.push_back(cyc - last_sync);
        last_sync = cyc;
      end
      if (stop_at_store && e.we && e.ab == 16'h0300) begin hit = 1; return; end
      rdy = 1'b1;
      if (!e.we && e.ab == 16'h0021 && stall_cnt < 3) begin rdy = 1'b0; stall_cnt++; end
      if (e.we && !wstall_done) begin rdy = 1'b0; wstall_done = 1; end
      if (rdy || e.we) void'(expq.pop_front());
      cyc++; budget++;
      if (budget > 2000) begin
        errors++; $display("FAIL timeout: queue still holds %0d cycles", expq.size());
        return;
      end
      @(negedge clk);
    end
  endtask

  function automatic int gap(input int k);
    return (k < gaps.size()) ? gaps[k] : -1;
  endfunction

  initial begin
    logic [7:0] prog [0:57];
    prog = '{8'hA9,8'h80, 8'hA9,8'h00, 8'hA2,8'h10, 8'hBD,8'hF8,8'h12, 8'hA0,8'h01,
             8'hA9,8'hAA, 8'h99,8'h10,8'h00, 8'hA2,8'hFF, 8'hB5,8'h80, 8'hB1,8'h20,
             8'hB6,8'h30, 8'hBC,8'h00,8'h13, 8'h86,8'h40, 8'h8C,8'h41,8'h00, 8'hA4,8'h41,
             8'hEA, 8'h02, 8'hA0,8'h02, 8'h91,8'h20, 8'h95,8'hF0, 8'hAE,8'h00,8'h11,
             8'hB9,8'hFF,8'h00, 8'h9D,8'h00,8'h03, 8'h94,8'h50, 8'h96,8'h10, 8'h8D,8'h00,8'h03};
    for (int i = 0; i < 65536; i++) poke(i[15:0], 8'h00);
    for (int i = 0; i < 58; i++) poke(16'h0200 + i[15:0], prog[i]);
    poke(16'hFFFC, 8'h00); poke(16'hFFFD, 8'h02);
    poke(16'h0020, 8'hFF); poke(16'h0021, 8'h10); poke(16'h007F, 8'h3C);
    poke(16'h0101, 8'h42); poke(16'h1100, 8'hC3); poke(16'h1300, 8'h7E);
    poke(16'h1308, 8'h55); poke(16'h0300, 8'h5A);

    model_reset_and_build(26);
    chk("model_a", m_a, 8'h42); chk("model_x", m_x, 8'hC3); chk("model_y", m_y, 8'h02);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;
    run_phase(1'b1);
    chk("store_reset_reached", hit, 1);

    // Reset lands in the store's write cycle: the write must be dropped.
    reset = 1'b1; rdy = 1'b1;
    @(negedge clk);
    chk_reset_state("reset_mid_store");
    chk("mem_0300_kept", bus_mem[16'h0300], 8'h5A);

    chk("gap_lda_imm", gap(0), 2);      chk("gap_lda_imm0", gap(1), 2);
    chk("gap_lda_absx_cross", gap(3), 5); chk("gap_sta_absy", gap(6), 5);
    chk("gap_lda_zpx", gap(8), 4);      chk("gap_lda_indy_stall", gap(9), 9);
    chk("gap_stx_zp", gap(12), 3);      chk("gap_nop", gap(15), 2);
    chk("gap_illegal", gap(16), 2);     chk("gap_sta_indy", gap(18), 6);
    chk("gap_lda_absy_cross", gap(21), 5); chk("gap_sta_absx", gap(22), 5);
    chk("mem_0011", bus_mem[16'h0011], 8'hAA); chk("mem_0041", bus_mem[16'h0041], 8'h7E);
    chk("mem_1101", bus_mem[16'h1101], 8'hC3); chk("mem_03c3", bus_mem[16'h03C3], 8'h42);
    chk("mem_0013", bus_mem[16'h0013], 8'h02); chk("mem_0012", bus_mem[16'h0012], 8'hC3);

    // Second run: start near the top of memory so the PC wraps to $0000.
    poke(16'hFFFC, 8'hFE); poke(16'hFFFD, 8'hFF);
    poke(16'hFFFE, 8'hA9); poke(16'hFFFF, 8'h11);
    poke(16'h0000, 8'hA2); poke(16'h0001, 8'h22);
    poke(16'h0002, 8'hEA); poke(16'h0003, 8'hEA);
    model_reset_and_build(4);
    reset = 1'b0;
    last_sync = -1;
    run_phase(1'b0);
    chk("wrap_a", reg_a, 8'h11); chk("wrap_x", reg_x, 8'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
